// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle multiply/MTHI/MTLO and a W-cycle restoring divider.
// Define HILO_MADD_EN to build the signed MADD/MSUB accumulate path (ops 110/111).
module hilo_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         flush,
  input  logic         rd_hi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] hilo_rd
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  count;
  logic [W-1:0]   hi_q, lo_q;
  logic [W-1:0]   divisor, rem, quo;
  logic           neg_quo, neg_rem, div_zero;

  logic           accept, is_div, signed_div, a_neg, b_neg, mul_signed;
  logic [W-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*W-1:0] a_ext, b_ext, prod;
  logic [W:0]     rem_sh, trial;
`ifdef HILO_MADD_EN
  logic [2*W-1:0] acc;
`endif

  assign accept     = (state == IDLE) && start && !flush;
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_div = (op == OP_DIV);
  assign a_neg      = signed_div && src_a[W-1];
  assign b_neg      = signed_div && src_b[W-1];
  assign mag_a      = a_neg ? -src_a : src_a;
  assign mag_b      = b_neg ? -src_b : src_b;

  // Sign-extending both operands to 2W bits makes one modulo-2^2W multiplier serve signed and unsigned.
  assign mul_signed = (op != OP_MULTU);
  assign a_ext      = {{W{mul_signed & src_a[W-1]}}, src_a};
  assign b_ext      = {{W{mul_signed & src_b[W-1]}}, src_b};
  assign prod       = a_ext * b_ext;
`ifdef HILO_MADD_EN
  assign acc        = op[0] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

  assign rem_sh  = {rem, quo[W-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign quo_fix = neg_quo ? -quo : quo;
  assign rem_fix = neg_rem ? -rem : rem;

  assign busy    = (state != IDLE);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign hilo_rd = rd_hi ? hi_q : lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_div) state_nxt = DIV;
      DIV:     if (flush) state_nxt = IDLE;
               else if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done     <= 1'b0;
      count    <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {hi_q, lo_q} <= prod;
              done         <= 1'b1;
            end
            OP_MTHI: begin
              hi_q <= src_a;
              done <= 1'b1;
            end
            OP_MTLO: begin
              lo_q <= src_a;
              done <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              divisor  <= mag_b;
              quo      <= mag_a;
              rem      <= '0;
              count    <= CW'(W);
              neg_quo  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= (src_b == '0);
            end
`ifdef HILO_MADD_EN
            OP_MADD, OP_MSUB: begin
              {hi_q, lo_q} <= acc;
              done         <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        // A borrow out of the trial subtraction means the divisor did not fit: keep the shifted remainder.
        DIV: begin
          if (flush) begin
            count <= '0;
          end else begin
            rem   <= trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
            quo   <= {quo[W-2:0], ~trial[W]};
            count <= count - CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            lo_q <= div_zero ? '1 : quo_fix;
            hi_q <= rem_fix;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO pushed at issue, popped when done pulses.
module tb_hilo_muldiv;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic         clk = 1'b0;
  logic         rst, start, flush, rd_hi;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo, hilo_rd;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_hi, model_lo;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .rd_hi(rd_hi), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .hilo_rd(hilo_rd)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour built from the language's own arithmetic operators.
  function automatic exp_t modelOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input exp_t cur);
    exp_t r;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] v;
    int ia, ib;
    r  = cur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    ia = a;
    ib = b;
    case (o)
      OP_MULT:  begin v = 64'(sa * sb); r.hi = v[63:32]; r.lo = v[31:0]; end
      OP_MULTU: begin v = ua * ub;      r.hi = v[63:32]; r.lo = v[31:0]; end
      OP_DIV: begin
        if (b == 0) begin r.lo = '1; r.hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = a; r.hi = '0; end
        else begin r.lo = ia / ib; r.hi = ia % ib; end
      end
      OP_DIVU: begin
        if (b == 0) begin r.lo = '1; r.hi = a; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      OP_MTHI: r.hi = a;
      OP_MTLO: r.lo = a;
      OP_MADD: begin v = {cur.hi, cur.lo} + 64'(sa * sb); r.hi = v[63:32]; r.lo = v[31:0]; end
      OP_MSUB: begin v = {cur.hi, cur.lo} - 64'(sa * sb); r.hi = v[63:32]; r.lo = v[31:0]; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issueOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = modelOp(o, a, b, '{model_hi, model_lo});
    exp_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic collectResult(input string tag, input int exp_busy);
    exp_t e;
    int   busy_cycles;
    bit   got;
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < W + 10 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "/done"}, 64'(got), 64'd1);
    checkOutput({tag, "/busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got) begin
        checkOutput({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, "/hi"}, 64'(hi), 64'(e.hi));
        checkOutput({tag, "/lo"}, 64'(lo), 64'(e.lo));
        rd_hi = 1'b1; #1;
        checkOutput({tag, "/rd_hi"}, 64'(hilo_rd), 64'(e.hi));
        rd_hi = 1'b0; #1;
        checkOutput({tag, "/rd_lo"}, 64'(hilo_rd), 64'(e.lo));
        @(posedge clk); #1;
        checkOutput({tag, "/done_width"}, 64'(done), 64'd0);
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
    issueOp(o, a, b);
    collectResult(tag, (o == OP_DIV || o == OP_DIVU) ? W + 1 : 0);
  endtask

  task automatic countDone(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      @(posedge clk); #1;
    end
    checkOutput({tag, "/no_done"}, 64'(n), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; rd_hi = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/hi", 64'(hi), 64'd0);
    checkOutput("reset/lo", 64'(lo), 64'd0);
    checkOutput("reset/busy", 64'(busy), 64'd0);
    checkOutput("reset/done", 64'(done), 64'd0);
    checkOutput("reset/hilo_rd", 64'(hilo_rd), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult");
    checkOutput("mult/hi_const", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult/lo_const", 64'(lo), 64'hFFFF_FFFE);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    checkOutput("multu/hi_const", 64'(hi), 64'h1);
    checkOutput("multu/lo_const", 64'(lo), 64'hFFFF_FFFE);

    // Reset in the middle of a divide throws everything away.
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid/hi", 64'(hi), 64'd0);
    checkOutput("rst_mid/lo", 64'(lo), 64'd0);
    checkOutput("rst_mid/busy", 64'(busy), 64'd0);
    checkOutput("rst_mid/done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b1;
    model_hi = '0; model_lo = '0;
    @(posedge clk); #1;
    countDone("rst_mid", W + 5);
    checkOutput("rst_mid/busy_after", 64'(busy), 64'd0);

    applyStimulus(OP_DIV, -32'sd7, 32'd2, "div_neg");
    checkOutput("div_neg/lo_const", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_neg/hi_const", 64'(hi), 64'hFFFF_FFFF);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, "divu");
    checkOutput("divu/lo_const", 64'(lo), 64'd14);
    checkOutput("divu/hi_const", 64'(hi), 64'd2);
    applyStimulus(OP_DIVU, 32'd5, 32'd0, "divu_zero");
    checkOutput("divu_zero/lo_const", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("divu_zero/hi_const", 64'(hi), 64'd5);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checkOutput("div_ovf/lo_const", 64'(lo), 64'h8000_0000);
    checkOutput("div_ovf/hi_const", 64'(hi), 64'd0);
    applyStimulus(OP_DIV, -32'sd9, 32'd0, "div_zero_neg");

    // Flush during the tenth divide iteration leaves HI/LO alone.
    applyStimulus(OP_MTHI, 32'h1111, 32'd0, "mthi");
    applyStimulus(OP_MTLO, 32'h2222, 32'd0, "mtlo");
    op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    checkOutput("flush/busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush/busy_after", 64'(busy), 64'd0);
    countDone("flush", W + 5);
    checkOutput("flush/hi", 64'(hi), 64'h1111);
    checkOutput("flush/lo", 64'(lo), 64'h2222);

    // A start raised while busy must be ignored.
    issueOp(OP_DIVU, 32'd100, 32'd7);
    op = OP_MTHI; src_a = 32'hDEAD_BEEF; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busy_start/hi", 64'(hi), 64'h1111);
    collectResult("busy_start", W + 1 - 2);

    // Flush wins over start in IDLE.
    op = OP_MTHI; src_a = 32'h5555; flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_idle/done", 64'(done), 64'd0);
    checkOutput("flush_idle/hi", 64'(hi), 64'(model_hi));

    applyStimulus(OP_MTHI, 32'd0, 32'd0, "madd_pre_hi");
    applyStimulus(OP_MTLO, 32'd5, 32'd0, "madd_pre_lo");
`ifdef HILO_MADD_EN
    applyStimulus(OP_MADD, 32'd3, -32'sd4, "madd");
    checkOutput("madd/hi_const", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("madd/lo_const", 64'(lo), 64'hFFFF_FFF9);
    applyStimulus(OP_MSUB, 32'd7, 32'd9, "msub");
`else
    op = OP_MADD; src_a = 32'd3; src_b = -32'sd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("madd_off/busy", 64'(busy), 64'd0);
    countDone("madd_off", 4);
    checkOutput("madd_off/hi", 64'(hi), 64'd0);
    checkOutput("madd_off/lo", 64'(lo), 64'd5);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'(i % 4);
      a = $urandom;
      b = $urandom;
      if (i >= 4) b = b >> (i * 3);
      if (b == 0) b = 32'd1;
      applyStimulus(o, a, b, $sformatf("rand%0d", i));
    end

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised successor to the HI/LO register: holds the W-bit HI/LO pair and owns the multiply/divide datapath that writes it. It sits beside the EX/MEM stage. Multiplies and MTHI/MTLO complete in one cycle. Divides run as a W-cycle iterative restoring divider with a busy/done handshake that the hazard unit uses to stall the pipeline.

## Interface
- W, 32: operand width; HI and LO are each W bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low; releases synchronously to clk.
- start  in  1  request strobe; sampled at a rising edge while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- src_a  in  W  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- src_b  in  W  rt operand: divisor or multiplier.
- flush  in  1  abort an in-flight divide (exception or branch squash).
- rd_hi  in  1  read select for hilo_rd: 1 selects HI, 0 selects LO.
- busy  out  1  divide in progress; stall request.
- done  out  1  one-cycle pulse in the first cycle new HI/LO values are visible.
- hi  out  W  current HI.
- lo  out  W  current LO.
- hilo_rd  out  W  rd_hi ? hi : lo, for MFHI/MFLO.

## Operation
- States: IDLE, DIV, FIX.
- IDLE with start=1 and flush=0:
  - MULT/MULTU: the 2W-bit product (signed or unsigned) is written to {HI,LO} at this edge.
  - MTHI: HI <= src_a, LO is unchanged.
  - MTLO: LO <= src_a, HI is unchanged.
  - MADD/MSUB: {HI,LO} <= {HI,LO} ± signed product, computed modulo 2^(2W).
  - DIV/DIVU: the operand magnitudes and sign flags are latched, the counter is loaded with W, and the FSM moves to DIV.
- DIV: one restoring step per cycle (shift the remainder, trial-subtract the divisor, set the quotient bit). The counter decrements each step; when it reaches 0 the FSM moves to FIX.
- FIX:
  - Sign correction: the quotient is negated if the operand signs differ (DIV only); the remainder takes the sign of the dividend.
  - Writeback: LO <= quotient, HI <= remainder. The FSM returns to IDLE.
- Divide by zero: runs the full latency; result is LO = all ones, HI = src_a.
- Signed overflow (0x80000000 / -1 at W=32): LO = 0x80000000, HI = 0.
- start while busy=1 is ignored. The issuing stage must hold the instruction until busy=0.
- flush in DIV or FIX: the FSM returns to IDLE at that edge. HI/LO are unchanged and no done pulse is produced.
- flush=1 with start=1 in IDLE: the request is dropped. Flush wins.
- Opcodes 110/111 without MADD_EN: no state change and no done.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, hilo_rd=0, FSM=IDLE, counter=0.
- Single-cycle ops (accepted at edge k):
  - The new value is visible after edge k.
  - done=1 for the cycle after edge k.
  - busy stays 0.
- Divide (accepted at edge k):
  - busy=1 from after edge k through the cycle ending at edge k+W+1, i.e. W+1 cycles.
  - HI/LO update at edge k+W+1.
  - done=1 and busy=0 in the following cycle.
  - A new start is accepted at edge k+W+2 at the earliest.
- done is registered: never combinational from start.
- hi, lo and hilo_rd are combinational from the registers only, with no bypass of in-flight results.
- rst asserted mid-divide: everything returns to reset values immediately; the partial result is discarded.

## Configuration
- HILO_MADD_EN defined: op 110 (MADD) and op 111 (MSUB) are implemented as signed multiply-accumulate into {HI,LO}, with single-cycle latency.
- HILO_MADD_EN undefined: the accumulator adder and subtractor are not built; ops 110/111 are treated as no-ops as described in Operation.

## Test plan
- Reset low mid-divide, then release -> hi=lo=0, busy=0, done=0, and no done pulse for the aborted divide.
- MULT 0xFFFFFFFF × 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. Each gives a 1-cycle done with busy=0.
- DIV -7 / 2 -> busy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, with done in the cycle busy falls. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5 after full latency. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Start DIV, raise flush in iteration 10 -> back to IDLE next cycle, HI/LO keep pre-divide values, no done. A start during busy -> ignored.
- With HILO_MADD_EN: HI=0, LO=5, MADD 3 × -4 -> {HI,LO} = -7, i.e. 0xFFFFFFFF/0xFFFFFFF9. Without HILO_MADD_EN: op 110 -> no change, no done.
